// File: rtl/pattern_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_loader_pkg
//  Purpose  : Shared board types, pattern codes and LFSR helpers for the loader
//  Revision : 1.0
// ============================================================================
package pattern_loader_pkg;

    localparam int POS_W  = 8;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef logic [POS_W-1:0]  pos_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [2:0] {
        PAT_CLEAR   = 3'd0,
        PAT_GLIDER  = 3'd1,
        PAT_BLINKER = 3'd2,
        PAT_RPENT   = 3'd3,
        PAT_RANDOM  = 3'd4
    } pattern_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Unassigned codes 5-7 collapse to clear
    function automatic pattern_t decode_pattern(input logic [2:0] code);
        case (code)
            3'd1:    return PAT_GLIDER;
            3'd2:    return PAT_BLINKER;
            3'd3:    return PAT_RPENT;
            3'd4:    return PAT_RANDOM;
            default: return PAT_CLEAR;
        endcase
    endfunction

    // x^16+x^14+x^13+x^11+1, shifting left, feedback into the LSB
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_rom.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_rom
//  Purpose  : 8x8 seed-pattern ROM; returns one pattern row, bit n = column n
//  Revision : 1.0
// ============================================================================
module pattern_rom
    import pattern_loader_pkg::*;
(
    input  pattern_t   i_pattern,
    input  logic [2:0] i_dy,
    output logic [7:0] o_row
);

    always_comb begin
        o_row = 8'h00;
        case (i_pattern)
            PAT_GLIDER: begin
                case (i_dy)
                    3'd0:    o_row = 8'b0000_0010;
                    3'd1:    o_row = 8'b0000_0100;
                    3'd2:    o_row = 8'b0000_0111;
                    default: o_row = 8'h00;
                endcase
            end
            PAT_BLINKER: begin
                if (i_dy == 3'd1) begin
                    o_row = 8'b0000_0111;
                end
            end
            PAT_RPENT: begin
                case (i_dy)
                    3'd0:    o_row = 8'b0000_0110;
                    3'd1:    o_row = 8'b0000_0011;
                    3'd2:    o_row = 8'b0000_0010;
                    default: o_row = 8'h00;
                endcase
            end
            default: o_row = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pattern_loader.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_loader
//  Purpose  : Streams one full board of pattern or LFSR words into the buffer
//  Revision : 1.0
// ============================================================================
module pattern_loader
    import pattern_loader_pkg::*;
#(
    parameter int BOARD_W = 256,
    parameter int BOARD_H = 256,
    parameter int WORD_W  = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [2:0]  pattern_in,
    input  pos_t        x_in,
    input  pos_t        y_in,
    input  logic [15:0] seed_in,
    output addr_t       addr_w_out,
    output data_t       data_w_out,
    output logic        wr_en_out,
    output logic        busy_out,
    output logic        done_out
);

    localparam int C_WORDS_PER_ROW = BOARD_W / WORD_W;
    localparam int C_N_WORDS       = BOARD_W * BOARD_H / WORD_W;
    localparam int C_WCOL_W        = $clog2(C_WORDS_PER_ROW);
    localparam int C_ROW_W         = $clog2(BOARD_H);
    localparam int C_COL_W         = $clog2(BOARD_W);
    localparam int C_BIT_W         = $clog2(WORD_W);
    localparam int C_CNT_W         = C_WCOL_W + C_ROW_W;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_N_WORDS - 1);

    state_t               r_state;
    pattern_t             r_pat;
    logic [C_COL_W-1:0]   r_x;
    logic [C_ROW_W-1:0]   r_y;
    logic [15:0]          r_lfsr;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_s1_valid;
    logic [C_CNT_W-1:0]   r_s1_cnt;
    logic [15:0]          r_s1_lfsr;
    logic                 r_fin;
    addr_t                r_addr;
    data_t                r_data;
    logic                 r_wr_en;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic [C_ROW_W-1:0]   w_row;
    logic [C_WCOL_W-1:0]  w_wcol;
    logic [C_ROW_W-1:0]   w_dy;
    logic                 w_dy_hit;
    logic [7:0]           w_rom_row;
    logic [WORD_W-1:0]    w_pat_bits;
    logic [WORD_W-1:0]    w_rnd_bits;
    data_t                w_word;

    // busy still covers the drain cycles after the FSM is back in IDLE
    assign w_accept = start_in && (r_state == ST_IDLE) && !r_busy;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_pat      <= PAT_CLEAR;
            r_x        <= '0;
            r_y        <= '0;
            r_lfsr     <= '0;
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_cnt   <= '0;
            r_s1_lfsr  <= '0;
            r_fin      <= 1'b0;
        end else begin
            r_s1_valid <= 1'b0;
            r_fin      <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        r_pat   <= decode_pattern(pattern_in);
                        r_x     <= C_COL_W'(x_in);
                        r_y     <= C_ROW_W'(y_in);
                        r_lfsr  <= (seed_in == 16'h0000) ? LFSR_DEFAULT_SEED : seed_in;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_cnt      <= r_cnt + 1'b1;
                    r_lfsr     <= lfsr_next(r_lfsr);
                    r_s1_valid <= 1'b1;
                    r_s1_cnt   <= r_cnt;
                    r_s1_lfsr  <= r_lfsr;
                    if (r_cnt == C_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_row    = r_s1_cnt[C_CNT_W-1:C_WCOL_W];
    assign w_wcol   = r_s1_cnt[C_WCOL_W-1:0];
    assign w_dy     = w_row - r_y;
    assign w_dy_hit = (w_dy[C_ROW_W-1:3] == '0);

    pattern_rom u_rom (
        .i_pattern (r_pat),
        .i_dy      (w_dy[2:0]),
        .o_row     (w_rom_row)
    );

    // Modular subtraction in C_COL_W bits gives the toroidal wrap for free
    generate
        for (genvar j = 0; j < WORD_W; j++) begin : g_bit
            logic [C_COL_W-1:0] w_dx;
            assign w_dx          = {w_wcol, C_BIT_W'(j)} - r_x;
            assign w_pat_bits[j] = w_dy_hit && (w_dx[C_COL_W-1:3] == '0) && w_rom_row[w_dx[2:0]];
            assign w_rnd_bits[j] = r_s1_lfsr[j % 16];
        end
    endgenerate

    assign w_word = (r_pat == PAT_RANDOM) ? w_rnd_bits : w_pat_bits;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wr_en <= r_s1_valid;
            r_addr  <= r_s1_valid ? ADDR_W'(r_s1_cnt) : '0;
            r_data  <= r_s1_valid ? w_word : '0;
            r_busy  <= (r_state != ST_IDLE) || r_fin;
            r_done  <= r_fin;
        end
    end

    assign addr_w_out = r_addr;
    assign data_w_out = r_data;
    assign wr_en_out  = r_wr_en;
    assign busy_out   = r_busy;
    assign done_out   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pattern_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pattern_loader
//  Purpose  : Self-checking bench for pattern_loader against a cell-level model
//  Revision : 1.0
// ============================================================================
module tb_pattern_loader;
    import pattern_loader_pkg::*;

    localparam int BW  = 256;
    localparam int BH  = 256;
    localparam int WW  = 16;
    localparam int WPR = BW / WW;
    localparam int N   = BW * BH / WW;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [2:0]  pattern_in;
    pos_t        x_in;
    pos_t        y_in;
    logic [15:0] seed_in;
    addr_t       addr_w_out;
    data_t       data_w_out;
    logic        wr_en_out;
    logic        busy_out;
    logic        done_out;

    int total = 0;
    int bad   = 0;
    int n_writes = 0;
    int n_done   = 0;

    logic [15:0] exp_words [N];
    logic [15:0] dut_mem   [N];
    logic [15:0] rnd_copy  [N];

    bit m_active = 1'b0;
    int m_e      = 0;

    pattern_loader #(.BOARD_W(BW), .BOARD_H(BH), .WORD_W(WW)) dut (
        .clk_in     (clk),
        .rst_in     (rst_in),
        .start_in   (start_in),
        .pattern_in (pattern_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .seed_in    (seed_in),
        .addr_w_out (addr_w_out),
        .data_w_out (data_w_out),
        .wr_en_out  (wr_en_out),
        .busy_out   (busy_out),
        .done_out   (done_out)
    );

    always #5 clk = ~clk;

    function automatic bit rom_bit(input int p, input int dy, input int dx);
        case (p)
            1: return (dy == 0 && dx == 1) || (dy == 1 && dx == 2) || (dy == 2 && dx <= 2);
            2: return (dy == 1 && dx <= 2);
            3: return (dy == 0 && (dx == 1 || dx == 2)) || (dy == 1 && dx <= 1) || (dy == 2 && dx == 1);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return ((s << 1) & 16'hFFFF) | {15'd0, fb};
    endfunction

    function automatic void build_expected(input int p, input int x, input int y, input logic [15:0] seed);
        logic [15:0] s;
        logic [15:0] w;
        int row, wc, c, dx, dy;
        s = (seed == 16'h0000) ? 16'hACE1 : seed;
        for (int a = 0; a < N; a++) begin
            w = 16'h0000;
            if (p == 4) begin
                w = s;
                s = lfsr_step(s);
            end else begin
                row = a / WPR;
                wc  = a % WPR;
                for (int j = 0; j < WW; j++) begin
                    c  = wc * WW + j;
                    dx = ((c - x) % BW + BW) % BW;
                    dy = ((row - y) % BH + BH) % BH;
                    if (dx < 8 && dy < 8 && rom_bit(p, dy, dx)) w[j] = 1'b1;
                end
            end
            exp_words[a] = w;
        end
    endfunction

    // Model: tracks edges elapsed since an accepted start
    always @(posedge clk) begin
        if (rst_in) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_e = m_e + 1;
            if (m_e == N + 3) m_active = 1'b0;
        end else if (start_in) begin
            m_active = 1'b1;
            m_e      = 0;
            build_expected(int'(pattern_in), int'(x_in), int'(y_in), seed_in);
        end
    end

    // Compare process: every cycle, sampled on the falling edge
    always @(negedge clk) begin
        logic        e_wr, e_busy, e_done;
        logic [11:0] e_addr;
        logic [15:0] e_data;
        e_wr = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_addr = 12'd0; e_data = 16'd0;
        if (m_active) begin
            e_busy = (m_e >= 1) && (m_e <= N + 2);
            e_wr   = (m_e >= 2) && (m_e <= N + 1);
            e_done = (m_e == N + 2);
            if (e_wr) begin
                e_addr = 12'(m_e - 2);
                e_data = exp_words[m_e - 2];
            end
        end
        total = total + 1;
        if ({wr_en_out, busy_out, done_out, addr_w_out, data_w_out} !== {e_wr, e_busy, e_done, e_addr, e_data}) begin
            bad = bad + 1;
            $display("FAIL cycle e=%0d act=%0b: got wr=%b busy=%b done=%b addr=%0d data=%h, want wr=%b busy=%b done=%b addr=%0d data=%h",
                     m_e, m_active, wr_en_out, busy_out, done_out, addr_w_out, data_w_out,
                     e_wr, e_busy, e_done, e_addr, e_data);
        end
        if (wr_en_out === 1'b1) begin
            n_writes = n_writes + 1;
            dut_mem[addr_w_out] = data_w_out;
        end
        if (done_out === 1'b1) n_done = n_done + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic run_load(input int p, input int x, input int y, input logic [15:0] seed,
                            input int restart_at, input int rst_at);
        @(negedge clk);
        n_writes   = 0;
        n_done     = 0;
        pattern_in = 3'(p);
        x_in       = pos_t'(x);
        y_in       = pos_t'(y);
        seed_in    = seed;
        start_in   = 1'b1;
        @(negedge clk);
        start_in   = 1'b0;
        pattern_in = 3'($urandom);
        x_in       = pos_t'($urandom);
        y_in       = pos_t'($urandom);
        seed_in    = 16'($urandom);
        for (int i = 0; i < N + 6; i++) begin
            @(negedge clk);
            start_in = (restart_at >= 0 && n_writes == restart_at);
            if (rst_at >= 0 && n_writes == rst_at) begin
                rst_in = 1'b1;
                @(negedge clk);
                rst_in = 1'b0;
                break;
            end
        end
        start_in = 1'b0;
        if (rst_at < 0) begin
            check("write_count", n_writes, N);
            check("done_pulses", n_done, 1);
        end else begin
            check("writes_after_reset_stop", (n_writes <= rst_at + 1), 1);
        end
    endtask

    initial begin
        int nz;
        int diff;
        rst_in = 1'b1; start_in = 1'b0; pattern_in = 3'd0;
        x_in = '0; y_in = '0; seed_in = 16'h0000;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        check("reset_busy", busy_out, 0);
        check("reset_wr_en", wr_en_out, 0);

        // Glider at origin
        run_load(1, 0, 0, 16'h1234, -1, -1);
        check("glider_addr0", dut_mem[0], 16'h0002);
        check("glider_addr16", dut_mem[16], 16'h0004);
        check("glider_addr32", dut_mem[32], 16'h0007);

        // Glider wrapping across both board edges
        run_load(1, 254, 255, 16'h0000, -1, -1);
        check("wrap_addr4095", dut_mem[4095], 16'h8000);
        check("wrap_addr0", dut_mem[0], 16'h0001);
        check("wrap_addr31", dut_mem[31], 16'hC000);
        check("wrap_addr16", dut_mem[16], 16'h0001);

        // Random with zero seed, twice
        run_load(4, 3, 3, 16'h0000, -1, -1);
        check("rand_addr0", dut_mem[0], 16'hACE1);
        check("rand_addr1", dut_mem[1], 16'h59C3);
        for (int a = 0; a < N; a++) rnd_copy[a] = dut_mem[a];
        run_load(4, 77, 9, 16'h0000, -1, -1);
        diff = 0;
        for (int a = 0; a < N; a++) if (dut_mem[a] !== rnd_copy[a]) diff++;
        check("rand_repeatable", diff, 0);

        // Start re-asserted mid-load is ignored
        run_load(3, 100, 50, 16'h0000, 100, -1);

        // Reset mid-load, then a fresh load
        run_load(2, 5, 5, 16'h0000, -1, 2000);
        @(negedge clk);
        check("post_reset_busy", busy_out, 0);
        run_load(1, 0, 0, 16'h0000, -1, -1);

        // Unassigned code behaves as clear
        run_load(6, 10, 10, 16'h5555, -1, -1);
        nz = 0;
        for (int a = 0; a < N; a++) if (dut_mem[a] != 16'h0000) nz++;
        check("code6_all_zero", nz, 0);

        for (int r = 0; r < 4; r++) begin
            run_load(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), 16'($urandom), -1,
                     (r == 2) ? int'($urandom_range(1, 4000)) : -1);
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pattern_loader.md
# pattern_loader

Fills the life board with a known starting configuration by streaming full-width words into the double buffer's logic write port. It acts as the writer counterpart to the renderer's read-only sweep. On a start pulse it writes every word of the board exactly once: each word is either an 8×8 pattern from a small ROM, stamped at a toroidally wrapped position, or LFSR noise. The block sits beside `life_logic`. The top level muxes its `addr_w_out`/`data_w_out`/`wr_en_out` onto the buffer write port while `busy_out` is high, and the normal buffer swap then shows the loaded board.

## Interface
Parameters
- `BOARD_W`, default 256: board width in cells, a power of two and a multiple of `WORD_W`.
- `BOARD_H`, default 256: board height in cells, a power of two.
- `WORD_W`, default 16: cells per buffer word; must equal the `data_t` width.

Ports
- `clk_in`  in  1: system clock (130 MHz domain). One clock; reset is synchronous and active-high.
- `rst_in`  in  1: synchronous active-high reset.
- `start_in`  in  1: one-cycle load request; honoured only in IDLE.
- `pattern_in`  in  3: pattern select. 0 = clear, 1 = glider, 2 = blinker, 3 = R-pentomino, 4 = random; 5–7 are treated as clear.
- `x_in`, `y_in`  in  `pos_t`: top-left cell of the pattern, taken modulo `BOARD_W`/`BOARD_H`.
- `seed_in`  in  16: LFSR seed, used for pattern 4 only.
- `addr_w_out`  out  `addr_t`: word address = row × (`BOARD_W`/`WORD_W`) + word column.
- `data_w_out`  out  `data_t`: word to write. Bit j is cell column word_col × `WORD_W` + j, so the LSB is the leftmost cell.
- `wr_en_out`  out  1: write strobe.
- `busy_out`  out  1: high from the cycle after start is accepted through the cycle `done_out` is high.
- `done_out`  out  1: one-cycle pulse when the load completes.

## Operation
- States:
  - IDLE → RUN on `start_in`. On entry, latch `pattern_in`, `x_in`, `y_in` and the seed, and clear the word counter.
  - RUN → DONE after word N−1 is issued, where N = `BOARD_W`×`BOARD_H`/`WORD_W`.
  - DONE → IDLE unconditionally.
- Seed handling: a latched seed of 0 is replaced by 16'hACE1.
- Word counter: increments by one per cycle in RUN, with no stalls.
  - Row = counter / words-per-row; word column = counter mod words-per-row. Both are bit slices, since all sizes are powers of two.
- Pattern bits (patterns 1–3), computed per word bit j at cell column c = wcol × `WORD_W` + j:
  - dx = (c − x) mod `BOARD_W` and dy = (row − y) mod `BOARD_H`.
  - The bit is set iff dx < 8, dy < 8 and ROM[pattern][dy][dx] is 1.
- ROM contents, as row: set columns:
  - Glider: r0: 1; r1: 2; r2: 0, 1, 2.
  - Blinker: r1: 0, 1, 2.
  - R-pentomino: r0: 1, 2; r1: 0, 1; r2: 1.
  - All other ROM entries are 0. Clear writes all-zero words.
- Random (pattern 4):
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting left with feedback into the LSB.
  - The written word is the current LFSR state; the LFSR advances once per word.
  - When `WORD_W` > 16, the state is replicated to fill the word.
- `start_in` in RUN or DONE is ignored; it is not queued.
- `rst_in` at any time, including mid-load:
  - The state returns to IDLE.
  - `wr_en_out`, `busy_out` and `done_out` are 0 on the next edge; `addr_w_out` and `data_w_out` are 0.
  - No further writes occur. A partially written board is acceptable.

## Timing
- Reset values: all outputs are 0.
- Start timing: with `start_in` sampled high at edge t, `busy_out` = 1 after edge t+1.
- Write timing:
  - Outputs are registered with one pipeline stage.
  - `wr_en_out` = 1 with address k after edge t+2+k, for k = 0..N−1.
  - The write stream is contiguous and in ascending address order.
- Completion:
  - `done_out` = 1 for exactly one cycle, after edge t+N+2; `busy_out` is still 1 in that cycle.
  - After edge t+N+3, `busy_out` = 0 and a new start is accepted.
- Total load time: N+3 cycles from the start edge to IDLE, which is 4099 cycles for the defaults.
- Inputs other than `start_in` and `rst_in` are ignored outside the start cycle.

## Structure
- Shared package:
  - Existing `pos_t`, `addr_t`, `data_t`.
  - New `pattern_t` enum for the five pattern codes.
  - `LFSR_DEFAULT_SEED` = 16'hACE1.
- Sub-module `pattern_rom`: purely combinational; takes (pattern, dy[2:0], dx[2:0]) and returns 1 bit.
  - `pattern_loader` instantiates `WORD_W` copies, or one copy returning an 8-bit row that is then indexed per bit.

## Test plan
1. Glider at (0,0), defaults → exactly 4096 writes. addr 0 = 16'h0002, addr 16 = 16'h0004, addr 32 = 16'h0007, every other word 0. `done_out` one pulse at start+4098.
2. Wrap case: glider at (254,255) → addr 4095 = 16'h8000, addr 0 = 16'h0001, addr 31 = 16'hC000, addr 16 = 16'h0001, all others 0.
3. Random with seed_in = 0 → addr 0 = 16'hACE1. addr 1 = the next LFSR state (0x59C3, per the polynomial and shift direction above). Rerunning with the same seed gives an identical stream.
4. `start_in` re-asserted at write 100 → no restart. Write count stays 4096, with a single `done_out`.
5. `rst_in` at write 2000 → `wr_en_out`/`busy_out` are 0 the next cycle. A fresh start then writes 4096 words from addr 0.
6. pattern_in = 6 at (10,10) → all 4096 words are 0.
